// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the sequential divider
package div_pkg;
   localparam int DEF_WIDTH = 4;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: (WIDTH+1)-bit trial subtract T - {0,D}, no_borrow is the carry-out of T + ~D + 1
module div_trial_sub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   t,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] diff,
   output logic             no_borrow
);
   logic carry_low;
   // low WIDTH bits of T + ~D + 1, then the top bit adds T[WIDTH] + ~0 + carry_low,
   // whose carry-out is T[WIDTH] | carry_low
   always_comb begin
      {carry_low, diff} = {1'b0, t[WIDTH-1:0]} + {1'b0, ~d} + (WIDTH+1)'(1);
      no_borrow = t[WIDTH] | carry_low;
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t           state, state_nxt;
   logic [WIDTH-1:0] q, r, d, q_nxt, r_nxt, diff;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   t;
   logic             no_borrow, accept, last, zero_div;
   div_trial_sub #(.WIDTH(WIDTH)) u_sub (
      .t         (t),
      .d         (d),
      .diff      (diff),
      .no_borrow (no_borrow)
   );
   // start is honoured in IDLE and DONE; the iteration datapath and next state follow
   always_comb begin
      accept    = start && (state != RUN);
      zero_div  = (divisor == '0);
      last      = (cnt == CW'(WIDTH - 1));
      t         = {r, q[WIDTH-1]};
      q_nxt     = WIDTH'({q, no_borrow});
      r_nxt     = no_borrow ? diff : t[WIDTH-1:0];
      state_nxt = accept ? (zero_div ? DONE : RUN) :
                  (state == RUN) ? (last ? DONE : RUN) : IDLE;
      busy      = (state == RUN);
      done      = (state == DONE);
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   // operand capture, shift iteration and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q           <= '0;
         r           <= '0;
         d           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         q   <= dividend;
         d   <= divisor;
         r   <= '0;
         cnt <= '0;
         if (zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         q   <= q_nxt;
         r   <= r_nxt;
         cnt <= cnt + 1'b1;
         if (last) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
         end
      end
   end
endmodule
